// File: rtl/bounce_gen_pkg.sv
// ----------------------------------------------------------------------------
// bounce_gen_pkg
// Shared types and constants for the contact-bounce emulator.
//   bounce_state_t : FSM state (IDLE / BOUNCE), 1 bit
//   LFSR_W         : width of the pseudo-random generator
//   LFSR_TAPS      : Fibonacci tap mask, taps 16,14,13,11
//   BURST_CNT_W    : width of the burst-window counter
// ----------------------------------------------------------------------------
package bounce_gen_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      BOUNCE = 1'b1
   } bounce_state_t;

   localparam int              LFSR_W      = 16;
   localparam logic [15:0]     LFSR_TAPS   = 16'hB400;
   localparam int              BURST_CNT_W = 24;

endpackage : bounce_gen_pkg

// File: rtl/bounce_gen_if.sv
// ----------------------------------------------------------------------------
// bounce_gen_if
// Level/status bundle of the bounce emulator.
//   clean      : clean input level (master -> slave)
//   enable     : 1 = emulate bounce, 0 = bypass (master -> slave)
//   noisy      : bouncing output level (slave -> master)
//   busy       : burst in progress (slave -> master)
//   settled    : one-cycle pulse when noisy is forced to the final level
//   toggle_cnt : noisy toggles in the current/last burst, only present when
//                BOUNCE_GEN_STATS_EN is defined
// Modports: master = stimulus side, slave = bounce_gen.
// ----------------------------------------------------------------------------
interface bounce_gen_if;

   logic clean;
   logic enable;
   logic noisy;
   logic busy;
   logic settled;

`ifdef BOUNCE_GEN_STATS_EN
   logic [15:0] toggle_cnt;

   modport master (output clean, enable,
                   input  noisy, busy, settled, toggle_cnt);
   modport slave  (input  clean, enable,
                   output noisy, busy, settled, toggle_cnt);
`else
   modport master (output clean, enable,
                   input  noisy, busy, settled);
   modport slave  (input  clean, enable,
                   output noisy, busy, settled);
`endif

endinterface : bounce_gen_if

// File: rtl/bounce_lfsr.sv
// ----------------------------------------------------------------------------
// bounce_lfsr
// Fibonacci LFSR that supplies toggle decisions and random hold lengths.
// The register only moves when 'advance' is high, so a burst always replays
// the same sequence from SEED after reset.
//   clk     : clock
//   reset   : asynchronous, active-high reset (q <= SEED)
//   advance : step the register this cycle
//   q       : current LFSR value
// ----------------------------------------------------------------------------
module bounce_lfsr
   import bounce_gen_pkg::*;
#(
   parameter int               WIDTH = LFSR_W,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [WIDTH-1:0] q
);

   logic feedback;

   assign feedback = ^(q & WIDTH'(LFSR_TAPS));

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= SEED;
      end else if (advance) begin
         q <= {q[WIDTH-2:0], feedback};
      end
   end

endmodule : bounce_lfsr

// File: rtl/bounce_gen.sv
// ----------------------------------------------------------------------------
// bounce_gen
// Contact-bounce emulator. On each level change of 'clean' it produces a
// pseudo-random toggle burst on 'noisy' lasting BOUNCE_CYCLES cycles, then
// forces 'noisy' to the new level. With enable low it is a one-cycle delay.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : bounce_gen_if.slave (clean, enable in; noisy, busy, settled out)
// Optional: define BOUNCE_GEN_STATS_EN to add bus.toggle_cnt, the number of
// noisy toggles in the current/last burst (saturating at 16'hFFFF).
// ----------------------------------------------------------------------------
module bounce_gen
   import bounce_gen_pkg::*;
#(
   parameter int          BOUNCE_CYCLES = 250000,
   parameter int          MIN_HOLD      = 4,
   parameter int          HOLD_RAND_W   = 4,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic          clk,
   input  logic          reset,
   bounce_gen_if.slave   bus
);

   // Hold counter must hold MIN_HOLD-1 + (2^HOLD_RAND_W - 1) without wrap.
   localparam int HOLD_W_A = HOLD_RAND_W + 1;
   localparam int HOLD_W_B = $clog2(MIN_HOLD + 2**HOLD_RAND_W);
   localparam int HOLD_W   = (HOLD_W_A > HOLD_W_B) ? HOLD_W_A : HOLD_W_B;

   localparam logic [BURST_CNT_W-1:0] BURST_RELOAD = BURST_CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]      HOLD_BASE    = HOLD_W'(MIN_HOLD - 1);

   bounce_state_t           state;
   logic                    target;
   logic                    noisy_q;
   logic                    busy_q;
   logic                    settled_q;
   logic [BURST_CNT_W-1:0]  burst_cnt;
   logic [HOLD_W-1:0]       hold_cnt;
   logic [LFSR_W-1:0]       lfsr_q;

   logic                    lfsr_advance;
   logic                    level_event;
   logic                    hold_done;
   logic                    burst_done;
   logic [HOLD_W-1:0]       hold_reload;

   // Only bit 0 and bits [HOLD_RAND_W:1] drive decisions; fold the rest.
   logic                    unused_lfsr_bits;
   assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:HOLD_RAND_W+1];

   // The LFSR moves only while a burst is actually running; bypass freezes it.
   assign lfsr_advance = (state == BOUNCE) && bus.enable;

   // A new target level: starts a burst in IDLE, retriggers one in BOUNCE.
   assign level_event  = bus.enable && (bus.clean != target);
   assign hold_done    = (hold_cnt == '0);
   assign burst_done   = (burst_cnt == '0);
   assign hold_reload  = HOLD_BASE + HOLD_W'(lfsr_q[HOLD_RAND_W:1]);

   bounce_lfsr #(
      .WIDTH (LFSR_W),
      .SEED  (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (lfsr_advance),
      .q       (lfsr_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         target    <= 1'b0;
         noisy_q   <= 1'b0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         burst_cnt <= '0;
         hold_cnt  <= '0;
      end else begin
         settled_q <= 1'b0;

         if (!bus.enable) begin
            // Bypass: abort any burst and track clean with one cycle of lag.
            state   <= IDLE;
            target  <= bus.clean;
            noisy_q <= bus.clean;
            busy_q  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (level_event) begin
                     target    <= bus.clean;
                     burst_cnt <= BURST_RELOAD;
                     hold_cnt  <= '0;
                     state     <= BOUNCE;
                     busy_q    <= 1'b1;
                  end
               end

               BOUNCE: begin
                  burst_cnt <= burst_cnt - 1'b1;
                  if (!hold_done) begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end else begin
                     if (lfsr_q[0]) begin
                        noisy_q <= ~noisy_q;
                     end
                     hold_cnt <= hold_reload;
                  end

                  // Later assignments win: retrigger beats settle, and the
                  // settle overrides a toggle scheduled in the same cycle.
                  if (level_event) begin
                     target    <= bus.clean;
                     burst_cnt <= BURST_RELOAD;
                  end else if (burst_done) begin
                     noisy_q   <= target;
                     settled_q <= 1'b1;
                     state     <= IDLE;
                     busy_q    <= 1'b0;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.noisy   = noisy_q;
   assign bus.busy    = busy_q;
   assign bus.settled = settled_q;

`ifdef BOUNCE_GEN_STATS_EN
   logic [15:0] toggle_cnt;
   logic        toggle_fire;

   // A toggle that lands on the settling cycle is overridden, so not counted.
   assign toggle_fire = (state == BOUNCE) && bus.enable && hold_done && lfsr_q[0]
                        && !(burst_done && !level_event);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_cnt <= '0;
      end else if (level_event) begin
         toggle_cnt <= '0;
      end else if (toggle_fire && (toggle_cnt != 16'hFFFF)) begin
         toggle_cnt <= toggle_cnt + 16'd1;
      end
   end

   assign bus.toggle_cnt = toggle_cnt;
`endif

endmodule : bounce_gen

// File: tb/tb_bounce_gen.sv
// ----------------------------------------------------------------------------
// tb_bounce_gen
// Self-checking bench for bounce_gen (BOUNCE_CYCLES=64, MIN_HOLD=2,
// HOLD_RAND_W=2, SEED=16'hACE1). A cycle model pushes the expected outputs
// into a scoreboard queue before each edge; the monitor pops and compares
// them on the following falling edge. Scenario-level checks (burst length,
// settle pulses, bypass lag, replay from SEED) are done on observed traces.
// Define BOUNCE_GEN_STATS_EN to also check toggle_cnt.
// ----------------------------------------------------------------------------
module tb_bounce_gen;

   localparam int          BC     = 64;
   localparam int          MH     = 2;
   localparam int          HRW    = 2;
   localparam logic [15:0] SEED_V = 16'hACE1;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   bounce_gen_if bus ();

   bounce_gen #(
      .BOUNCE_CYCLES (BC),
      .MIN_HOLD      (MH),
      .HOLD_RAND_W   (HRW),
      .SEED          (SEED_V)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        noisy;
      logic        busy;
      logic        settled;
      logic [15:0] tog;
   } obs_t;

   obs_t        sb[$];
   logic        m_bounce, m_target, m_noisy, m_busy, m_settled;
   logic [15:0] m_lfsr;
   int          m_burst, m_hold, m_tog;

   task automatic model_reset();
      m_bounce = 0; m_target = 0; m_noisy = 0; m_busy = 0; m_settled = 0;
      m_lfsr = SEED_V; m_burst = 0; m_hold = 0; m_tog = 0;
      sb.delete();
   endtask

   task automatic model_step();
      logic        c, e;
      logic [15:0] l;
      int          hold_now, burst_now;
      c = bus.clean;
      e = bus.enable;
      m_settled = 0;
      if (!e) begin
         m_bounce = 0; m_target = c; m_noisy = c; m_busy = 0;
      end else if (!m_bounce) begin
         if (c != m_target) begin
            m_target = c; m_burst = BC - 1; m_hold = 0;
            m_bounce = 1; m_busy = 1; m_tog = 0;
         end
      end else begin
         l = m_lfsr;
         m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         hold_now  = m_hold;
         burst_now = m_burst;
         m_burst--;
         if (m_hold > 0) m_hold--;
         if (hold_now == 0) begin
            if (l[0] && !(burst_now == 0 && c == m_target)) begin
               m_noisy = !m_noisy;
               if (m_tog < 65535) m_tog++;
            end
            m_hold = MH - 1 + int'(l[2:1]);
         end
         if (c != m_target) begin
            m_target = c; m_burst = BC - 1; m_tog = 0;
         end else if (burst_now == 0) begin
            m_noisy = m_target; m_settled = 1; m_bounce = 0; m_busy = 0;
         end
      end
   endtask

   // ---------------- monitor state ----------------
   int          busy_n, settled_n, edges_n;
   logic        prev_noisy;
   logic [31:0] trace;

   task automatic clear_stats();
      busy_n = 0; settled_n = 0; edges_n = 0; trace = '0;
   endtask

   function automatic logic [15:0] dut_tog();
`ifdef BOUNCE_GEN_STATS_EN
      return bus.toggle_cnt;
`else
      return 16'd0;
`endif
   endfunction

   // One clock: predict, push, clock, sample on the falling edge, compare.
   task automatic cycle(input string tag);
      obs_t exp_v, got_v;
      model_step();
      exp_v.noisy   = m_noisy;
      exp_v.busy    = m_busy;
      exp_v.settled = m_settled;
`ifdef BOUNCE_GEN_STATS_EN
      exp_v.tog     = 16'(m_tog);
`else
      exp_v.tog     = 16'd0;
`endif
      sb.push_back(exp_v);
      @(posedge clk);
      @(negedge clk);
      got_v = {bus.noisy, bus.busy, bus.settled, dut_tog()};
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         exp_v = sb.pop_front();
         check(tag, 32'(got_v), 32'(exp_v));
      end
      if (bus.busy) busy_n++;
      if (bus.settled) settled_n++;
      if (bus.busy && (bus.noisy != prev_noisy)) edges_n++;
      prev_noisy = bus.noisy;
      trace = {trace[30:0], bus.noisy};
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   // Asynchronous reset asserted between edges; outputs must drop at once.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      check(tag, 32'({bus.noisy, bus.busy, bus.settled}), 32'd0);
      model_reset();
      prev_noisy = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [31:0] golden;
   int          lag_err, s3_edges;
   logic        c_edge, s3_prev;

   initial begin
      bus.clean  = 1'b0;
      bus.enable = 1'b1;
      @(negedge clk);
      do_reset("reset_state");

      // 1: rising clean, single burst
      clear_stats();
      bus.clean = 1'b1;
      run("s1", 32);
      golden = trace;
      run("s1", 48);
      check("s1_busy_cycles", 32'(busy_n), 32'(BC));
      check("s1_settled_cnt", 32'(settled_n), 32'd1);
      check("s1_has_toggle", 32'(edges_n > 0), 32'd1);
      check("s1_final_noisy", 32'(bus.noisy), 32'd1);
`ifdef BOUNCE_GEN_STATS_EN
      check("s6_toggle_cnt", 32'(bus.toggle_cnt), 32'(edges_n));
`endif
      run("s1_hold", 10);
      check("s1_noisy_stays", 32'(bus.noisy), 32'd1);
`ifdef BOUNCE_GEN_STATS_EN
      check("s6_toggle_hold", 32'(bus.toggle_cnt), 32'(edges_n));
`endif

      // 2: clean glitches back at cycle 30 of a burst
      do_reset("s2_reset");
      bus.clean = 1'b1;
      run("s2", 30);
      clear_stats();
      bus.clean = 1'b0;
      run("s2", 100);
      check("s2_busy_after_change", 32'(busy_n), 32'(BC));
      check("s2_settled_cnt", 32'(settled_n), 32'd1);
      check("s2_final_noisy", 32'(bus.noisy), 32'd0);

      // 3: bypass, clean toggles every 5 cycles
      do_reset("s3_reset");
      clear_stats();
      bus.enable = 1'b0;
      lag_err  = 0;
      s3_edges = 0;
      s3_prev  = bus.noisy;
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) bus.clean = ~bus.clean;
         c_edge = bus.clean;
         cycle("s3");
         if (bus.noisy != c_edge) lag_err++;
         if (bus.noisy != s3_prev) s3_edges++;
         s3_prev = bus.noisy;
      end
      check("s3_lag_errors", 32'(lag_err), 32'd0);
      check("s3_noisy_edges", 32'(s3_edges), 32'd8);
      check("s3_busy_cycles", 32'(busy_n), 32'd0);
      check("s3_settled_cnt", 32'(settled_n), 32'd0);

      // 4: reset at cycle 20 of a burst, then replay from SEED
      bus.enable = 1'b1;
      bus.clean  = 1'b0;
      do_reset("s4_pre_reset");
      bus.clean = 1'b1;
      run("s4", 20);
      check("s4_busy_before", 32'(bus.busy), 32'd1);
      do_reset("s4_async_reset");
      clear_stats();
      run("s4_replay", 32);
      check("s4_replay_trace", trace, golden);
      run("s4_tail", 40);
      check("s4_final_noisy", 32'(bus.noisy), 32'd1);

      // 5: drop enable at cycle 10 of a burst
      bus.clean = 1'b0;
      do_reset("s5_reset");
      bus.clean = 1'b1;
      run("s5", 10);
      clear_stats();
      bus.enable = 1'b0;
      cycle("s5_abort");
      check("s5_busy_fell", 32'(bus.busy), 32'd0);
      cycle("s5_follow");
      check("s5_noisy_clean", 32'(bus.noisy), 32'd1);
      run("s5_tail", 8);
      check("s5_no_settled", 32'(settled_n), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_bounce_gen
